// File: rtl/vga_pixel_sink.sv
// Display end of the object-mux pixel interface: raster counters, sync/blank generation
// delayed to match the mux pipeline, and RRRGGGBB to 8:8:8 DAC expansion.
module vga_pixel_sink #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter int unsigned MUX_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pixel_en,
    input  logic [7:0]  RGBIn,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        startOfFrame,
    output logic        hsync,
    output logic        vsync,
    output logic        blankN,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    // Per-stage timing bits: [2] = hsync, [1] = vsync, [0] = active.
    localparam logic [2:0] TIMING_IDLE = 3'b110;

    logic [2:0]                        timing_raw;
    logic [MUX_LATENCY-1:0][2:0]       timing_dl;
    logic [MUX_LATENCY:0][2:0]         timing_shift;
    logic [2:0]                        timing_last;

    always_comb begin
        timing_raw[2] = !((pixelX >= HS_START) && (pixelX < HS_END));
        timing_raw[1] = !((pixelY >= VS_START) && (pixelY < VS_END));
        timing_raw[0] = (pixelX < H_ACT) && (pixelY < V_ACT);
        timing_shift  = {timing_dl, timing_raw};
        timing_last   = timing_shift[MUX_LATENCY];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pixelX       <= '0;
            pixelY       <= '0;
            startOfFrame <= 1'b0;
        end else begin
            startOfFrame <= 1'b0;
            if (pixel_en) begin
                if (pixelX == H_LAST) begin
                    pixelX <= '0;
                    if (pixelY == V_LAST) begin
                        pixelY       <= '0;
                        startOfFrame <= 1'b1;
                    end else begin
                        pixelY <= pixelY + 11'd1;
                    end
                end else begin
                    pixelX <= pixelX + 11'd1;
                end
            end
        end
    end

    // The delay line runs every clk, like the mux register it shadows.
    always_ff @(posedge clk) begin
        if (reset) begin
            timing_dl <= {MUX_LATENCY{TIMING_IDLE}};
            hsync     <= 1'b1;
            vsync     <= 1'b1;
            blankN    <= 1'b0;
            red       <= '0;
            green     <= '0;
            blue      <= '0;
        end else begin
            timing_dl <= timing_shift[MUX_LATENCY-1:0];
            hsync     <= timing_last[2];
            vsync     <= timing_last[1];
            blankN    <= timing_last[0];
            if (timing_last[0]) begin
                red   <= {RGBIn[7:5], RGBIn[7:5], RGBIn[7:6]};
                green <= {RGBIn[4:2], RGBIn[4:2], RGBIn[4:3]};
                blue  <= {4{RGBIn[1:0]}};
            end else begin
                red   <= '0;
                green <= '0;
                blue  <= '0;
            end
        end
    end

endmodule
